led_strand_driver: RTL and testbench

- WS2812-style serial LED strand transmitter in the clk_led domain.
- Reads the per-LED color held in led_color_buffer by driving next_led_request_address and sampling green_out/red_out/blue_out once color_valid is qualified.
- Serializes each 24-bit GRB word MSB-first as NRZ pulses on a single output pin.
- Prefetches the next LED while the current one shifts, so consecutive LEDs go out back-to-back, then inserts the latch/reset gap between frames.

---
 rtl/led_strand_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_led_strand_driver.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_strand_driver.sv
// WS2812-style LED strand transmitter.
// Fetches GRB words from an external color buffer and shifts them out MSB-first
// as NRZ pulses. While one LED is shifting, the next one is prefetched so that
// LEDs go out back-to-back. Each frame ends with a low latch gap.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | strand low, not busy, waiting for enable
// S_FETCH | strand low, waiting for the buffer to answer the held address
// S_SEND  | shifting the current LED; prefetching the next one meanwhile
// S_LATCH | strand low for CYCLES_RESET cycles, then frame_done
module led_strand_driver #(
  parameter int NUM_LEDS          = 50,
  parameter int LED_ADDRESS_WIDTH = $clog2(NUM_LEDS),
  parameter int CYCLES_T0H        = 35,
  parameter int CYCLES_T1H        = 70,
  parameter int CYCLES_BIT        = 125,
  parameter int CYCLES_RESET      = 5000,
  parameter int FETCH_SETTLE      = 3,
  parameter int FETCH_TIMEOUT     = 255
) (
  input  logic                         clk_led,
  input  logic                         rst_n,
  input  logic                         enable,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic                         strand_out,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         fetch_error
);

  localparam int BW = $clog2(CYCLES_BIT);
  localparam int LW = $clog2(CYCLES_RESET);
  localparam int FW = $clog2(FETCH_TIMEOUT);

  localparam logic [BW-1:0] BIT_LAST   = BW'(CYCLES_BIT - 1);
  localparam logic [BW-1:0] T0H        = BW'(CYCLES_T0H);
  localparam logic [BW-1:0] T1H        = BW'(CYCLES_T1H);
  localparam logic [LW-1:0] LATCH_LAST = LW'(CYCLES_RESET - 1);
  localparam logic [FW-1:0] SETTLE     = FW'(FETCH_SETTLE);
  localparam logic [FW-1:0] TMO_LAST   = FW'(FETCH_TIMEOUT - 1);
  localparam logic [LED_ADDRESS_WIDTH-1:0] ADDR_LAST = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

  state_t                       r_state;
  logic [LED_ADDRESS_WIDTH-1:0] r_addr;
  logic [FW-1:0]                r_fetch_cnt;
  logic                         r_fetch_active;
  logic                         r_pf_valid;
  logic [23:0]                  r_prefetch;
  logic [23:0]                  r_shift;
  logic [BW-1:0]                r_bit_cnt;
  logic [4:0]                   r_bit_idx;
  logic                         r_cur_last;
  logic [LW-1:0]                r_latch_cnt;
  logic                         r_strand;
  logic                         r_busy;
  logic                         r_frame_done;
  logic                         r_fetch_error;

  logic        w_fetch_on;
  logic        w_cap_ok;
  logic        w_timeout;
  logic        w_fetch_done;
  logic [23:0] w_fetch_data;
  logic        w_bit_end;
  logic        w_led_end;
  logic        w_pf_ready;
  logic [23:0] w_pf_data;
  logic        w_addr_last;
  logic [BW-1:0] w_cnt_inc;
  logic [BW-1:0] w_hi_time;

  // Fetch engine qualification: color_valid is only trusted once the held
  // address has settled, which masks stale answers for the previous address.
  assign w_fetch_on   = r_fetch_active &&
                        ((r_state == S_FETCH) || ((r_state == S_SEND) && !r_pf_valid));
  assign w_cap_ok     = w_fetch_on && (r_fetch_cnt >= SETTLE) && color_valid;
  assign w_timeout    = w_fetch_on && !w_cap_ok && (r_fetch_cnt == TMO_LAST);
  assign w_fetch_done = w_cap_ok || w_timeout;
  assign w_fetch_data = w_cap_ok ? {green_in, red_in, blue_in} : 24'h000000;

  assign w_bit_end   = (r_bit_cnt == BIT_LAST);
  assign w_led_end   = w_bit_end && (r_bit_idx == 5'd23);
  // A prefetch finishing on the very cycle the LED ends is used directly.
  assign w_pf_ready  = r_pf_valid || w_fetch_done;
  assign w_pf_data   = r_pf_valid ? r_prefetch : w_fetch_data;
  assign w_addr_last = (r_addr == ADDR_LAST);
  assign w_cnt_inc   = r_bit_cnt + BW'(1);
  assign w_hi_time   = r_shift[23] ? T1H : T0H;

  // Sequencer, fetch engine and bit serializer; all outputs registered.
  always_ff @(posedge clk_led or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_addr         <= '0;
      r_fetch_cnt    <= '0;
      r_fetch_active <= 1'b0;
      r_pf_valid     <= 1'b0;
      r_prefetch     <= '0;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_bit_idx      <= '0;
      r_cur_last     <= 1'b0;
      r_latch_cnt    <= '0;
      r_strand       <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_fetch_error  <= 1'b0;
    end else begin
      r_frame_done  <= 1'b0;
      r_fetch_error <= w_timeout;
      if (w_fetch_on && !w_fetch_done) r_fetch_cnt <= r_fetch_cnt + FW'(1);

      case (r_state)
        S_IDLE: begin
          r_strand <= 1'b0;
          if (enable) begin
            r_state        <= S_FETCH;
            r_busy         <= 1'b1;
            r_addr         <= '0;
            r_fetch_cnt    <= '0;
            r_fetch_active <= 1'b1;
            r_pf_valid     <= 1'b0;
          end
        end

        S_FETCH: begin
          r_strand <= 1'b0;
          if (w_fetch_done) begin
            r_state    <= S_SEND;
            r_shift    <= w_fetch_data;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_strand   <= 1'b1;
            r_cur_last <= w_addr_last;
            r_pf_valid <= 1'b0;
            if (!w_addr_last) begin
              r_addr         <= r_addr + LED_ADDRESS_WIDTH'(1);
              r_fetch_cnt    <= '0;
              r_fetch_active <= 1'b1;
            end else begin
              r_fetch_active <= 1'b0;
            end
          end
        end

        S_SEND: begin
          if (w_fetch_done) begin
            r_prefetch     <= w_fetch_data;
            r_pf_valid     <= 1'b1;
            r_fetch_active <= 1'b0;
          end
          if (!w_bit_end) begin
            r_bit_cnt <= w_cnt_inc;
            r_strand  <= (w_cnt_inc < w_hi_time);
          end else if (!w_led_end) begin
            // every bit period opens with the strand high
            r_bit_cnt <= '0;
            r_bit_idx <= r_bit_idx + 5'd1;
            r_shift   <= {r_shift[22:0], 1'b0};
            r_strand  <= 1'b1;
          end else if (r_cur_last) begin
            r_state     <= S_LATCH;
            r_latch_cnt <= '0;
            r_strand    <= 1'b0;
          end else if (w_pf_ready) begin
            r_shift    <= w_pf_data;
            r_bit_cnt  <= '0;
            r_bit_idx  <= '0;
            r_strand   <= 1'b1;
            r_pf_valid <= 1'b0;
            r_cur_last <= w_addr_last;
            if (!w_addr_last) begin
              r_addr         <= r_addr + LED_ADDRESS_WIDTH'(1);
              r_fetch_cnt    <= '0;
              r_fetch_active <= 1'b1;
            end else begin
              r_fetch_active <= 1'b0;
            end
          end else begin
            // prefetch still outstanding: finish it with the strand held low
            r_state  <= S_FETCH;
            r_strand <= 1'b0;
          end
        end

        S_LATCH: begin
          r_strand <= 1'b0;
          if (r_latch_cnt == LATCH_LAST) begin
            r_frame_done <= 1'b1;
            r_addr       <= '0;
            if (enable) begin
              r_state        <= S_FETCH;
              r_fetch_cnt    <= '0;
              r_fetch_active <= 1'b1;
              r_pf_valid     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_latch_cnt <= r_latch_cnt + LW'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign next_led_request_address = r_addr;
  assign strand_out               = r_strand;
  assign busy                     = r_busy;
  assign frame_done               = r_frame_done;
  assign fetch_error              = r_fetch_error;

endmodule

// File: tb/tb_led_strand_driver.sv
// Directed bench for led_strand_driver with a 3-LED strand and a color
// buffer model whose answers become valid a few cycles after an address change.
module tb_led_strand_driver;

  localparam int NL = 3;

  logic       clk_led = 1'b0;
  logic       rst_n   = 1'b0;
  logic       enable  = 1'b0;
  logic [1:0] addr;
  logic [7:0] g_in, r_in, b_in;
  logic       color_valid;
  logic       strand_out, busy, frame_done, fetch_error;

  led_strand_driver #(.NUM_LEDS(NL)) u_dut (
    .clk_led                  (clk_led),
    .rst_n                    (rst_n),
    .enable                   (enable),
    .next_led_request_address (addr),
    .green_in                 (g_in),
    .red_in                   (r_in),
    .blue_in                  (b_in),
    .color_valid              (color_valid),
    .strand_out               (strand_out),
    .busy                     (busy),
    .frame_done               (frame_done),
    .fetch_error              (fetch_error)
  );

  always #5 clk_led = ~clk_led;

  // Color buffer model: data follows the address one cycle late and is
  // flagged valid once the address has been stable for a few cycles.
  logic [23:0] mem [0:3];
  logic        kill1 = 1'b0;
  logic [1:0]  buf_addr = 2'd0;
  int          stable = 0;

  always @(posedge clk_led) begin
    if (addr != buf_addr) begin
      buf_addr <= addr;
      stable   <= 0;
    end else if (stable < 100) begin
      stable <= stable + 1;
    end
  end

  assign {g_in, r_in, b_in} = mem[buf_addr];
  assign color_valid = (stable >= 2) && !(kill1 && (buf_addr == 2'd1));

  // Strand / status monitor, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk_led) cyc++;

  int         rise_q[$];
  int         width_q[$];
  int         addr_q[$];
  int         hi_start = 0;
  int         fd_cnt = 0, fd_cyc = 0, err_cnt = 0, err_cyc = 0, a1_cyc = 0;
  logic       prev_s = 1'b0;
  logic [1:0] prev_a = 2'd0;

  always @(negedge clk_led) begin
    if (strand_out && !prev_s) begin
      rise_q.push_back(cyc);
      hi_start = cyc;
    end
    if (!strand_out && prev_s) width_q.push_back(cyc - hi_start);
    prev_s = strand_out;
    if (addr != prev_a) begin
      addr_q.push_back(int'(addr));
      if (addr == 2'd1) a1_cyc = cyc;
    end
    prev_a = addr;
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (fetch_error) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_mon();
    rise_q.delete();
    width_q.delete();
    addr_q.delete();
    fd_cnt  = 0;
    err_cnt = 0;
  endtask

  task automatic wait_rises(input int n, input int budget, input string tag);
    int k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk_led); #1;
      k++;
    end
    check(tag, 32'(rise_q.size() >= n), 32'd1);
  endtask

  task automatic wait_widths(input int n, input int budget, input string tag);
    int k = 0;
    while (width_q.size() < n && k < budget) begin
      @(negedge clk_led); #1;
      k++;
    end
    check(tag, 32'(width_q.size() >= n), 32'd1);
  endtask

  task automatic wait_fd(input int budget, input string tag);
    int start = fd_cnt;
    int k = 0;
    while (fd_cnt == start && k < budget) begin
      @(negedge clk_led); #1;
      k++;
    end
    check(tag, 32'(fd_cnt > start), 32'd1);
  endtask

  // Number of high pulses in one LED slot whose width disagrees with the GRB word.
  function automatic int bad_widths(input int base, input logic [23:0] c);
    int bad = 0;
    for (int i = 0; i < 24; i++) begin
      if (base + i >= width_q.size()) bad++;
      else if (width_q[base + i] != (c[23 - i] ? 70 : 35)) bad++;
    end
    return bad;
  endfunction

  // Number of consecutive rising edges among the first n not 125 cycles apart.
  function automatic int bad_intervals(input int n);
    int bad = 0;
    for (int i = 1; i < n; i++) begin
      if (i >= rise_q.size()) bad++;
      else if (rise_q[i] - rise_q[i - 1] != 125) bad++;
    end
    return bad;
  endfunction

  int seq;

  initial begin
    mem[0] = 24'h0; mem[1] = 24'h0; mem[2] = 24'h0; mem[3] = 24'h0;

    // Reset state
    repeat (3) @(negedge clk_led);
    check("rst_strand", 32'(strand_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_fdone", 32'(frame_done), 32'd0);
    check("rst_ferr", 32'(fetch_error), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_led);
    check("idle_busy", 32'(busy), 32'd0);

    // Frame A: FF0000 / AA0F81 / 00FF55, enable dropped during LED1
    mem[0] = 24'hFF0000; mem[1] = 24'hAA0F81; mem[2] = 24'h00FF55;
    clear_mon();
    enable = 1'b1;
    @(posedge clk_led); #1;
    check("a_busy_rise", 32'(busy), 32'd1);
    check("a_addr_start", 32'(addr), 32'd0);
    wait_rises(30, 8000, "a_wait_led1");
    enable = 1'b0;
    wait_fd(20000, "a_wait_fdone");
    check("a_busy_end", 32'(busy), 32'd0);
    check("a_addr_end", 32'(addr), 32'd0);
    check("a_rises", 32'(rise_q.size()), 32'd72);
    check("a_widths_n", 32'(width_q.size()), 32'd72);
    check("a_led0_w", 32'(bad_widths(0, 24'hFF0000)), 32'd0);
    check("a_led1_w", 32'(bad_widths(24, 24'hAA0F81)), 32'd0);
    check("a_led2_w", 32'(bad_widths(48, 24'h00FF55)), 32'd0);
    check("a_contig", 32'(bad_intervals(72)), 32'd0);
    if (rise_q.size() > 0)
      check("a_latch_gap", 32'(fd_cyc - rise_q[rise_q.size() - 1]), 32'd5125);
    check("a_addr_n", 32'(addr_q.size()), 32'd3);
    seq = 0;
    foreach (addr_q[i]) seq = (seq << 4) | addr_q[i];
    check("a_addr_seq", 32'(seq), 32'h120);
    repeat (300) @(negedge clk_led);
    #1;
    check("a_no_frame2", 32'(rise_q.size()), 32'd72);
    check("a_idle_busy", 32'(busy), 32'd0);
    check("a_fd_once", 32'(fd_cnt), 32'd1);

    // Frame B: LED1 never answers -> timeout, zeros sent, LED2 intact
    mem[0] = 24'h123456; mem[1] = 24'hFFFFFF; mem[2] = 24'hC3A50F;
    kill1 = 1'b1;
    clear_mon();
    enable = 1'b1;
    wait_rises(2, 200, "b_start");
    enable = 1'b0;
    wait_fd(20000, "b_wait_fdone");
    check("b_ferr_once", 32'(err_cnt), 32'd1);
    check("b_ferr_time", 32'(err_cyc - a1_cyc), 32'd255);
    check("b_rises", 32'(rise_q.size()), 32'd72);
    check("b_led0_w", 32'(bad_widths(0, 24'h123456)), 32'd0);
    check("b_led1_w", 32'(bad_widths(24, 24'h000000)), 32'd0);
    check("b_led2_w", 32'(bad_widths(48, 24'hC3A50F)), 32'd0);
    check("b_contig", 32'(bad_intervals(72)), 32'd0);
    kill1 = 1'b0;
    repeat (5) @(negedge clk_led);

    // Frame C: reset during bit 10 of LED1, then restart from LED0
    mem[0] = 24'h0F0FF0; mem[1] = 24'hFFFFFF; mem[2] = 24'h000001;
    clear_mon();
    enable = 1'b1;
    wait_rises(35, 6000, "c_wait_bit10");
    check("c_pre_strand", 32'(strand_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("c_rst_strand", 32'(strand_out), 32'd0);
    check("c_rst_busy", 32'(busy), 32'd0);
    check("c_rst_addr", 32'(addr), 32'd0);
    repeat (3) @(negedge clk_led);
    clear_mon();
    rst_n = 1'b1;
    wait_widths(24, 6000, "c_wait_led0");
    check("c_led0_w", 32'(bad_widths(0, 24'h0F0FF0)), 32'd0);
    check("c_contig", 32'(bad_intervals(24)), 32'd0);
    if (addr_q.size() > 0) check("c_first_pf", 32'(addr_q[0]), 32'd1);
    else check("c_first_pf", 32'hFFFF_FFFF, 32'd1);
    enable = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
